// File: rtl/arb_pkg.sv
// Shared constants and helpers for the 4-way round-robin mux arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    function automatic logic [N_REQ-1:0] onehot2(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first unmasked request after `last`, wrapping back to it.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [1:0]       idx
);

    logic [1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = last;
        cand  = last;
        // Visit last+1 .. last+3, then last itself
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand] && !mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 mux, with done/drop release and hold-limit preemption.
module mux_rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             preempt
);

    localparam int unsigned CW        = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
    localparam int unsigned HOLD_LAST = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_LAST);

    logic [0:0]       state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, preempt_q, preempt_d;

    logic             owner_req, others, timeout, release_own;
    logic [N_REQ-1:0] pick_mask;
    logic             pick_found;
    logic [1:0]       pick_idx;

    assign owner_req   = req[sel_q];
    assign others      = |(req & ~onehot2(sel_q));
    assign timeout     = (state_q == ST_OWN) && (HOLD_MAX != 0) && (cnt_q == CNT_LAST) && others;
    assign release_own = done || !owner_req || timeout;
    // Only a timeout excludes the owner from the next search
    assign pick_mask   = timeout ? onehot2(sel_q) : '0;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last_q),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_OWN;
                    grant_d = onehot2(pick_idx);
                    sel_d   = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (release_own) begin
                    cnt_d = '0;
                    if (pick_found) begin
                        grant_d   = onehot2(pick_idx);
                        sel_d     = pick_idx;
                        last_d    = pick_idx;
                        preempt_d = timeout && !done && owner_req;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= 2'd0;
            last_q    <= 2'd3;
            grant_q   <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            busy_q    <= |grant_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized scoreboard bench for mux_rr_arbiter against a queue-fed behavioural model.
module tb_mux_rr_arbiter;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;

    typedef struct {
        int         cyc;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       preempt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Model state: owner index or -1, last owner, mux select, owned cycles so far
    int m_owner = -1;
    int m_last  = 3;
    int m_sel   = 0;
    int m_held  = 0;
    bit m_pre   = 0;

    mux_rr_arbiter #(.HOLD_MAX(HM)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    function automatic int rr_search(input logic [3:0] r, input int from, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (from + k) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic take(input int w);
        m_owner = w;
        m_last  = w;
        m_sel   = w;
        m_held  = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic d, input logic rs);
        m_pre = 0;
        if (rs) begin
            m_owner = -1;
            m_last  = 3;
            m_sel   = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            int w;
            w = rr_search(r, m_last, -1);
            if (w >= 0) take(w);
        end else begin
            int  this_cycle;
            int  w;
            bit  other_wait;
            bit  to;
            this_cycle = m_held + 1;
            other_wait = 0;
            for (int i = 0; i < 4; i++) if (r[i] && i != m_owner) other_wait = 1;
            to = (HM != 0) && (this_cycle == HM) && other_wait;
            if (d || !r[m_owner] || to) begin
                w = rr_search(r, m_owner, to ? m_owner : -1);
                m_pre = to && !d && r[m_owner];
                if (w >= 0) take(w);
                else begin
                    m_owner = -1;
                    m_held  = 0;
                end
            end else begin
                m_held = (this_cycle == HM) ? 0 : this_cycle;
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic d, input logic rs);
        exp_t e;
        @(negedge clk);
        req  = r;
        done = d;
        rst  = rs;
        cyc++;
        model_step(r, d, rs);
        e.cyc     = cyc;
        e.grant   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e.sel     = 2'(m_sel);
        e.busy    = (m_owner >= 0);
        e.preempt = m_pre;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge issued by the driver
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (grant !== e.grant || sel !== e.sel || busy !== e.busy
                    || preempt !== e.preempt) begin
                    bad++;
                    $display("FAIL outputs cycle %0d: got grant=%b sel=%0d busy=%b preempt=%b, want grant=%b sel=%0d busy=%b preempt=%b",
                             e.cyc, grant, sel, busy, preempt, e.grant, e.sel, e.busy, e.preempt);
                end
            end
        end
    end

    initial begin
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b1010, 1'b0, 1'b0);
        // Done-driven rotation with everyone requesting
        step(4'b1111, 1'b0, 1'b0);
        repeat (4) begin
            step(4'b1111, 1'b1, 1'b0);
            step(4'b1111, 1'b0, 1'b0);
        end
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        // Hold-limit preemption: 0 owns while 2 waits
        step(4'b0001, 1'b0, 1'b0);
        repeat (8) step(4'b0101, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        // Lone requester never gets preempted
        repeat (10) step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        // Reset during ownership by requester 3
        repeat (3) step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b1);
        repeat (3) step(4'b1000, 1'b0, 1'b0);
        // Timeout and done together
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        repeat (3) step(4'b0110, 1'b0, 1'b0);
        step(4'b0110, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            logic [3:0] r;
            logic       d;
            logic       rs;
            r  = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = 4'b0001 << $urandom_range(0, 3);
            d  = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 80) == 0);
            step(r, d, rs);
        end
        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
